mem_access_unit: RTL and testbench

Sub-word load/store engine for the MEM stage of the five-stage pipeline. Sits between the EX/MEM pipeline register and the word-only data memory, which has a combinational read, a posedge write and no byte enables. The unit handles all of the following:
- extracts and extends bytes and halfwords on loads;
- implements `sb`/`sh` as a two-cycle read-modify-write that stalls the pipeline;
- blocks misaligned accesses and records the first fault address.

---
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Sub-word load/store engine for the MEM stage in front of a word-only data memory.
// Handles lane extraction and extension on loads, sb/sh read-modify-write, and misaligned-access faults.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              dm_mem_read,
    output logic              dm_mem_write,
    output logic [ADDR_W-1:0] dm_address,
    output logic [31:0]       dm_write_data,
    input  logic [31:0]       dm_read_data,
    output logic [31:0]       load_data,
    output logic              stall,
    output logic              misaligned,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MERGE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [31:0]       merge_word_q, merge_word_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

    logic              req_s, is_byte_s, is_half_s, is_word_s, mis_s;
    logic              rd_s, wr_s, stall_s;
    logic [31:0]       wdata_s, load_s;

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] data,
                                               input logic is_byte, input logic [1:0] lane);
        logic [31:0] res;
        res = word;
        if (is_byte) begin
            case (lane)
                2'd0:    res[7:0]   = data[7:0];
                2'd1:    res[15:8]  = data[7:0];
                2'd2:    res[23:16] = data[7:0];
                2'd3:    res[31:24] = data[7:0];
                default: res        = word;
            endcase
        end else if (lane[1]) begin
            res[31:16] = data[15:0];
        end else begin
            res[15:0] = data[15:0];
        end
        return res;
    endfunction

    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        h = lane[1] ? word[31:16] : word[15:0];
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        case (size)
            2'b00:   res = {{24{b[7] & ~uns}}, b};
            2'b01:   res = {{16{h[15] & ~uns}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    assign req_s     = mem_read | mem_write;
    assign is_byte_s = (mem_size == 2'b00);
    assign is_half_s = (mem_size == 2'b01);
    assign is_word_s = mem_size[1];
    assign mis_s     = req_s & ((is_half_s & addr[0]) | (is_word_s & (addr[1:0] != 2'b00)));

    // Request decode and next-state logic; a store wins over a simultaneous load.
    always_comb begin
        state_d      = state_q;
        merge_word_d = merge_word_q;
        rd_s         = 1'b0;
        wr_s         = 1'b0;
        stall_s      = 1'b0;
        wdata_s      = 32'h0000_0000;
        load_s       = 32'h0000_0000;
        case (state_q)
            S_IDLE: begin
                if (mis_s) begin
                    rd_s = 1'b0;
                end else if (mem_write) begin
                    if (is_word_s) begin
                        wr_s    = 1'b1;
                        wdata_s = store_data;
                    end else begin
                        rd_s         = 1'b1;
                        stall_s      = 1'b1;
                        merge_word_d = merge_lane(dm_read_data, store_data, is_byte_s, addr[1:0]);
                        state_d      = S_MERGE;
                    end
                end else if (mem_read) begin
                    rd_s   = 1'b1;
                    load_s = extract_lane(dm_read_data, mem_size, addr[1:0], mem_unsigned);
                end else begin
                    rd_s = 1'b0;
                end
            end
            S_MERGE: begin
                wr_s    = 1'b1;
                wdata_s = merge_word_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Only the first misaligned access after reset is recorded.
    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (mis_s && !fault_q) begin
            fault_d      = 1'b1;
            fault_addr_d = addr;
        end else begin
            fault_d = fault_q;
        end
    end

    // State, merge buffer and fault record registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            merge_word_q <= 32'h0000_0000;
            fault_q      <= 1'b0;
            fault_addr_q <= {ADDR_W{1'b0}};
        end else begin
            state_q      <= state_d;
            merge_word_q <= merge_word_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Strobes and stall are held off while reset is asserted so a held request cannot reach memory.
    assign dm_mem_read   = rd_s & rst_n;
    assign dm_mem_write  = wr_s & rst_n;
    assign stall         = stall_s & rst_n;
    assign dm_write_data = wdata_s;
    assign dm_address    = {addr[ADDR_W-1:2], 2'b00};
    assign load_data     = load_s;
    assign misaligned    = mis_s;
    assign fault         = fault_q;
    assign fault_addr    = fault_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-only memory behind it.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] addr, store_data;
    logic        dm_mem_read, dm_mem_write, stall, misaligned, fault;
    logic [31:0] dm_address, dm_write_data, dm_read_data, load_data, fault_addr;
    logic [31:0] mem [0:255];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .addr(addr), .store_data(store_data),
        .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write), .dm_address(dm_address),
        .dm_write_data(dm_write_data), .dm_read_data(dm_read_data), .load_data(load_data),
        .stall(stall), .misaligned(misaligned), .fault(fault), .fault_addr(fault_addr)
    );

    assign dm_read_data = mem[dm_address[9:2]];

    // Word memory: posedge write, no byte enables.
    always_ff @(posedge clk) begin
        if (dm_mem_write) mem[dm_address[9:2]] <= dm_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request on the falling edge and let combinational outputs settle.
    task automatic apply(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
        addr = a; store_data = d;
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] exp);
        apply(1'b1, 1'b0, sz, uns, a, 32'h0);
        chk(tag, load_data, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
        addr = 32'h0; store_data = 32'h0;
        #12;
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_dm_wr", {31'b0, dm_mem_write}, 32'h0);
        chk("rst_load", load_data, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        chk("rst_faddr", fault_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word path, with read+write priority check on the store
        apply(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
        chk("sw_wr", {31'b0, dm_mem_write}, 32'h1);
        chk("sw_stall", {31'b0, stall}, 32'h0);
        chk("sw_prio_load", load_data, 32'h0);
        chk("sw_wdata", dm_write_data, 32'h1122_3344);
        apply(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        chk("lw_data", load_data, 32'h1122_3344);
        chk("lw_stall", {31'b0, stall}, 32'h0);
        chk("lw_rd", {31'b0, dm_mem_read}, 32'h1);

        // Byte store read-modify-write
        apply(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
        apply(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB);
        chk("sb_stall1", {31'b0, stall}, 32'h1);
        chk("sb_rd1", {31'b0, dm_mem_read}, 32'h1);
        chk("sb_wr1", {31'b0, dm_mem_write}, 32'h0);
        apply(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB);
        chk("sb_stall2", {31'b0, stall}, 32'h0);
        chk("sb_wr2", {31'b0, dm_mem_write}, 32'h1);
        chk("sb_wdata", dm_write_data, 32'h1122_AB44);
        chk("sb_addr", dm_address, 32'h10);
        load_chk("sb_readback", 2'b10, 1'b0, 32'h10, 32'h1122_AB44);

        // Sub-word loads
        apply(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h8001_FF7F);
        load_chk("lb_40", 2'b00, 1'b0, 32'h40, 32'h0000_007F);
        load_chk("lb_41", 2'b00, 1'b0, 32'h41, 32'hFFFF_FFFF);
        load_chk("lbu_41", 2'b00, 1'b1, 32'h41, 32'h0000_00FF);
        load_chk("lb_43", 2'b00, 1'b0, 32'h43, 32'hFFFF_FF80);
        load_chk("lbu_42", 2'b00, 1'b1, 32'h42, 32'h0000_0001);
        load_chk("lh_42", 2'b01, 1'b0, 32'h42, 32'hFFFF_8001);
        load_chk("lhu_42", 2'b01, 1'b1, 32'h42, 32'h0000_8001);
        load_chk("lh_40", 2'b01, 1'b0, 32'h40, 32'hFFFF_FF7F);
        load_chk("lw_m_40", 2'b11, 1'b0, 32'h40, 32'h8001_FF7F);

        // Misalignment and first-fault capture
        apply(1'b0, 1'b1, 2'b10, 1'b0, 32'h44, 32'h5A5A_5A5A);
        apply(1'b1, 1'b0, 2'b10, 1'b0, 32'h43, 32'h0);
        chk("mis_flag", {31'b0, misaligned}, 32'h1);
        chk("mis_rd", {31'b0, dm_mem_read}, 32'h0);
        chk("mis_wr", {31'b0, dm_mem_write}, 32'h0);
        chk("mis_load", load_data, 32'h0);
        chk("mis_stall", {31'b0, stall}, 32'h0);
        apply(1'b0, 1'b1, 2'b01, 1'b0, 32'h45, 32'h0000_FFFF);
        chk("mis_sh_flag", {31'b0, misaligned}, 32'h1);
        chk("mis_sh_wr", {31'b0, dm_mem_write}, 32'h0);
        chk("mis_sh_stall", {31'b0, stall}, 32'h0);
        chk("fault_set", {31'b0, fault}, 32'h1);
        chk("fault_addr1", fault_addr, 32'h43);
        idle();
        chk("fault_addr2", fault_addr, 32'h43);
        chk("idle_mis", {31'b0, misaligned}, 32'h0);
        load_chk("mis_mem_kept", 2'b10, 1'b0, 32'h44, 32'h5A5A_5A5A);

        // Reset dropped during MERGE
        apply(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_00CD);
        chk("rr_stall1", {31'b0, stall}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rr_stall", {31'b0, stall}, 32'h0);
        chk("rr_wr", {31'b0, dm_mem_write}, 32'h0);
        chk("rr_fault", {31'b0, fault}, 32'h0);
        idle();
        rst_n = 1'b1;
        load_chk("rr_mem_kept", 2'b10, 1'b0, 32'h10, 32'h1122_AB44);

        // Back-to-back halfword stores
        apply(1'b0, 1'b1, 2'b10, 1'b0, 32'h50, 32'h0);
        apply(1'b0, 1'b1, 2'b01, 1'b0, 32'h50, 32'h0000_BEEF);
        chk("b2b_stall0", {31'b0, stall}, 32'h1);
        apply(1'b0, 1'b1, 2'b01, 1'b0, 32'h50, 32'h0000_BEEF);
        chk("b2b_stall1", {31'b0, stall}, 32'h0);
        chk("b2b_wdata1", dm_write_data, 32'h0000_BEEF);
        apply(1'b0, 1'b1, 2'b01, 1'b0, 32'h52, 32'h0000_CAFE);
        chk("b2b_stall2", {31'b0, stall}, 32'h1);
        apply(1'b0, 1'b1, 2'b01, 1'b0, 32'h52, 32'h0000_CAFE);
        chk("b2b_stall3", {31'b0, stall}, 32'h0);
        chk("b2b_wdata2", dm_write_data, 32'hCAFE_BEEF);
        load_chk("b2b_final", 2'b10, 1'b0, 32'h50, 32'hCAFE_BEEF);
        idle();
        chk("end_stall", {31'b0, stall}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
